// File: rtl/mfp_audio_sfx_mixer_if.sv
// Shared sample-ROM read bus: the mixer drives the address, and the ROM
// returns the sample one cycle later.
interface mfp_audio_sfx_mixer_if #(
   parameter int SAMPLE_W = 8,
   parameter int ADDR_W   = 12
);
   logic [ADDR_W-1:0]   mem_addr;
   logic [SAMPLE_W-1:0] mem_data;

   modport master (output mem_addr, input  mem_data);
   modport slave  (input  mem_addr, output mem_data);
endinterface

// File: rtl/mfp_audio_sfx_mixer.sv
// Multi-channel sfx player and mixer. On every sample tick, each channel's
// next sample is fetched from the shared ROM in turn. The signed offsets
// are summed with saturation, and the result drives a PWM DAC.
module mfp_audio_sfx_mixer #(
   parameter int N_CH       = 4,
   parameter int SAMPLE_W   = 8,
   parameter int ADDR_W     = 12,
   parameter int SAMPLE_DIV = 4096
)(
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [N_CH-1:0]          play,
   input  logic [N_CH-1:0]          loop,
   input  logic [N_CH-1:0]          stop,
   input  logic [N_CH*ADDR_W-1:0]   ch_base,
   input  logic [N_CH*ADDR_W-1:0]   ch_len,
   mfp_audio_sfx_mixer_if.master    mem,
   output logic [N_CH-1:0]          active,
   output logic [N_CH-1:0]          done,
   output logic                     AUD_PWM,
   output logic                     AUD_SD
);
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SUM_W = SAMPLE_W + 3;
   localparam int MIDI  = 1 << (SAMPLE_W - 1);
   localparam logic [SAMPLE_W-1:0]     MID_V  = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(MIDI - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-MIDI);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_MIX} state_t;

   logic [N_CH-1:0][ADDR_W-1:0]   base_a, len_a, ptr;
   logic [N_CH-1:0][SAMPLE_W-1:0] samp;
   logic [DIV_W-1:0]              tick_cnt;
   logic                          tick;
   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [ADDR_W-1:0]             mem_addr_q;
   logic signed [SUM_W-1:0]       sum;
   logic [SAMPLE_W-1:0]           mix_d, mix_level;
   logic [SAMPLE_W-1:0]           pwm_cnt;

   assign base_a       = ch_base;
   assign len_a        = ch_len;
   assign mem.mem_addr = mem_addr_q;
   assign tick         = (tick_cnt == DIV_W'(SAMPLE_DIV - 1));

   // Sample-rate divider: tick is asserted for one cycle on each wrap.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn)  tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;

   // Fetch FSM state register.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end

   // Fetch sequencing: the FSM walks ADDR/DATA once per channel, then MIX.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: if (tick) begin state_d = S_ADDR; idx_d = '0; end
         S_ADDR: state_d = S_DATA;
         S_DATA: if (idx_q == IDX_W'(N_CH - 1)) state_d = S_MIX;
                 else begin state_d = S_ADDR; idx_d = idx_q + 1'b1; end
         default: state_d = S_IDLE;
      endcase
   end

   // The address is loaded on entry to ADDR(i), so the ROM data is valid during DATA(i).
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn)                mem_addr_q <= '0;
      else if (state_d == S_ADDR)  mem_addr_q <= base_a[idx_d] + ptr[idx_d];

   // Sample capture: an idle channel contributes the midline, which is silence.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         for (int i = 0; i < N_CH; i++) samp[i] <= MID_V;
      end else if (state_q == S_DATA) begin
         samp[idx_q] <= active[idx_q] ? mem.mem_data : MID_V;
      end

   // Signed sum of channel offsets, saturated, then rebiased to offset-binary.
   always_comb begin
      sum = '0;
      for (int i = 0; i < N_CH; i++)
         sum = sum + {{3{~samp[i][SAMPLE_W-1]}}, ~samp[i][SAMPLE_W-1], samp[i][SAMPLE_W-2:0]};
      if (sum > SAT_HI)      mix_d = '1;
      else if (sum < SAT_LO) mix_d = '0;
      else                   mix_d = sum[SAMPLE_W-1:0] ^ MID_V;
   end

   // The mix level is registered once per sample, in MIX.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn)              mix_level <= MID_V;
      else if (state_q == S_MIX) mix_level <= mix_d;

   // Per-channel control. Priority is stop, then play, then the MIX advance.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         ptr    <= '0;
         active <= '0;
         done   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            done[i] <= 1'b0;
            if (stop[i]) begin
               active[i] <= 1'b0;
            end else if (play[i] && len_a[i] != '0) begin
               ptr[i]    <= '0;
               active[i] <= 1'b1;
            end else if (state_q == S_MIX && active[i]) begin
               if (ptr[i] == len_a[i] - 1'b1) begin
                  ptr[i] <= '0;
                  if (!loop[i]) begin
                     active[i] <= 1'b0;
                     done[i]   <= 1'b1;
                  end
               end else begin
                  ptr[i] <= ptr[i] + 1'b1;
               end
            end
         end
      end

   // PWM DAC and amplifier enable. The amplifier enable follows active by one cycle.
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         pwm_cnt <= '0;
         AUD_SD  <= 1'b0;
         AUD_PWM <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         AUD_SD  <= |active;
         AUD_PWM <= (pwm_cnt < mix_level) & AUD_SD;
      end
endmodule

// File: doc/mfp_audio_sfx_mixer.md
Name: mfp_audio_sfx_mixer

Overview:
Multi-channel sound-effect player and mixer, the parametrised successor to the single-voice sfx block. It plays N_CH independent sample streams from one shared synchronous sample ROM, each with play/loop/stop control. It sums the streams with saturation and drives the board PWM audio pin and amplifier enable. It sits between the game/IO-register logic (which issues per-channel commands) and the AUD_PWM/AUD_SD pins.

Parameters:
N_CH, 4, number of independent sfx channels (1..8)
SAMPLE_W, 8, sample width in bits; ROM samples are unsigned offset-binary, midline 2^(SAMPLE_W-1)
ADDR_W, 12, sample ROM address width
SAMPLE_DIV, 4096, HCLK cycles per output sample tick; must be >= 2*N_CH+4

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
play  in  N_CH  per-channel single-cycle start pulse
loop  in  N_CH  per-channel loop mode level, sampled at each end-of-sample
stop  in  N_CH  per-channel single-cycle stop pulse
ch_base  in  N_CH*ADDR_W  channel i ROM start address in bits [i*ADDR_W +: ADDR_W]
ch_len  in  N_CH*ADDR_W  channel i length in samples, same packing
mem_addr  out  ADDR_W  shared ROM read address
mem_data  in  SAMPLE_W  ROM read data, valid exactly 1 cycle after mem_addr
active  out  N_CH  channel i currently playing
done  out  N_CH  1-cycle pulse when a non-looping channel finishes
AUD_PWM  out  1  PWM audio output
AUD_SD  out  1  amplifier enable, 1 = on

Behaviour:
- Reset (async, HRESETn=0): all ptrs=0, active=0, done=0, mem_addr=0, tick counter=0, FSM=IDLE, mix_level=2^(SAMPLE_W-1), pwm_cnt=0, AUD_PWM=0, AUD_SD=0. Reset mid-playback aborts all channels; no done pulse.
- Tick counter counts 0..SAMPLE_DIV-1 and wraps. Its wrap asserts tick for one cycle.
- Commands, evaluated every cycle per channel:
  - stop beats play in the same cycle: active<=0, no done.
  - play with ch_len!=0: ptr<=0, active<=1. This restarts the channel if it is already active.
  - play with ch_len==0 is ignored.
- Fetch FSM states: IDLE -> ADDR(i) -> DATA(i) for i=0..N_CH-1 -> MIX -> IDLE.
  - Entered on tick.
  - ADDR(i): mem_addr<=ch_base[i]+ptr[i], truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
  - DATA(i): capture mem_data as samp[i] if active[i] at this cycle, else samp[i]=midline.
  - MIX: mix_level updated. Each active channel's ptr advances.
  - The whole sequence takes 2*N_CH+1 cycles after tick.
- Mix arithmetic:
  - Per channel, s_i = samp[i] - 2^(SAMPLE_W-1), signed SAMPLE_W bits.
  - Sum is taken in SAMPLE_W+3 signed bits.
  - The sum saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], then 2^(SAMPLE_W-1) is added back. The result is registered as mix_level.
- Pointer advance in MIX, per active channel:
  - If ptr==ch_len-1 and loop=1: ptr<=0.
  - If ptr==ch_len-1 and loop=0: active<=0, done pulses 1 cycle, ptr<=0.
  - Otherwise ptr<=ptr+1.
  - A play or stop in the MIX cycle overrides the advance for that channel.
- play or stop during a fetch takes effect immediately. A channel whose ADDR slot has already passed uses its new state at the next tick.
- PWM: pwm_cnt is a free-running SAMPLE_W-bit counter, wrapping every 2^SAMPLE_W cycles. AUD_PWM is registered as (pwm_cnt < mix_level) & AUD_SD.
- AUD_SD is registered as |active, one cycle after active changes.
- When all channels are idle, mix_level returns to midline at the next MIX.

Test Plan:
- Reset: hold HRESETn=0 for 100 cycles -> active=0, AUD_SD=0, AUD_PWM=0, mix_level=0x80. Release -> no activity for 10 ticks.
- Single play: ch0 base=0x100, len=4, loop=0, ROM[0x100..0x103]=0x90,0xA0,0x70,0x80; pulse play[0] -> mix_level sequence 0x90,0xA0,0x70,0x80, then done[0] pulses once, active[0]=0, mix_level=0x80, AUD_SD drops.
- Loop then stop: ch1 len=3, loop=1 -> addresses base, base+1, base+2, base, ... for 9 ticks with no done. stop[1] -> active[1]=0 and no done pulse.
- Mixing/saturation: ch0 and ch1 both play constant 0xF0 -> mix_level=0xFF (saturated, not wrapped). Both play 0x10 -> 0x00. 0xA0 plus 0x70 -> 0x90.
- Simultaneous events: play[2] and stop[2] in the same cycle -> active[2] stays 0. play[0] while ch0 is at ptr=2 -> ptr restarts at 0 on the next tick. play with len=0 -> ignored.
- Address wrap and PWM: base=0xFFE, len=4 -> mem_addr 0xFFE,0xFFF,0x000,0x001. With mix_level=0x40, AUD_PWM duty = 64/256 over one PWM period.
